// File: rtl/regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_if
//   Bundles the decode-issue, writeback and register-file write signals of the
//   decode-stage scoreboard.
//   master : decode / writeback sources / register file side (test driver)
//   slave  : the scoreboard itself
//   Issue group     : issue_valid, issue_use_rs1/2, issue_rs1/2_addr,
//                     issue_rd_write, issue_rd_addr -> issue_stall, issue_fire
//   ALU writeback   : alu_wb_valid/addr/data -> alu_wb_ready
//   Load writeback  : mem_wb_valid/addr/data -> mem_wb_ready
//   Regfile port    : rf_write_enable, rf_write_addr, rf_write_data
//   Status          : busy_count, wb_unexpected
// ---------------------------------------------------------------------------
interface regfile_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              issue_valid;
    logic              issue_use_rs1;
    logic              issue_use_rs2;
    logic [ADDR_W-1:0] issue_rs1_addr;
    logic [ADDR_W-1:0] issue_rs2_addr;
    logic              issue_rd_write;
    logic [ADDR_W-1:0] issue_rd_addr;
    logic              issue_stall;
    logic              issue_fire;

    logic              alu_wb_valid;
    logic [ADDR_W-1:0] alu_wb_addr;
    logic [DATA_W-1:0] alu_wb_data;
    logic              alu_wb_ready;

    logic              mem_wb_valid;
    logic [ADDR_W-1:0] mem_wb_addr;
    logic [DATA_W-1:0] mem_wb_data;
    logic              mem_wb_ready;

    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;

    logic [ADDR_W:0]   busy_count;
    logic              wb_unexpected;

    modport master (
        output issue_valid, issue_use_rs1, issue_use_rs2, issue_rs1_addr,
               issue_rs2_addr, issue_rd_write, issue_rd_addr,
               alu_wb_valid, alu_wb_addr, alu_wb_data,
               mem_wb_valid, mem_wb_addr, mem_wb_data,
        input  issue_stall, issue_fire, alu_wb_ready, mem_wb_ready,
               rf_write_enable, rf_write_addr, rf_write_data,
               busy_count, wb_unexpected
    );

    modport slave (
        input  issue_valid, issue_use_rs1, issue_use_rs2, issue_rs1_addr,
               issue_rs2_addr, issue_rd_write, issue_rd_addr,
               alu_wb_valid, alu_wb_addr, alu_wb_data,
               mem_wb_valid, mem_wb_addr, mem_wb_data,
        output issue_stall, issue_fire, alu_wb_ready, mem_wb_ready,
               rf_write_enable, rf_write_addr, rf_write_data,
               busy_count, wb_unexpected
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Decode-stage register-file scoreboard: one busy bit per architectural
//   register, RAW/WAW issue stall, round-robin arbitration of the single
//   register-file write port between ALU and load writeback, and registered
//   write-port outputs.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : regfile_scoreboard_if.slave (issue, writeback, write port, status)
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_scoreboard_if.slave   bus
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    logic [NUM_REGS-1:0] r_busy;
    src_e                r_last_grant;
    logic                r_wr_vld_p1;
    logic [ADDR_W-1:0]   r_wr_addr_p1;
    logic [DATA_W-1:0]   r_wr_data_p1;
    logic                r_wb_unexpected;

    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_stall;
    logic                w_fire;
    logic                w_grant_alu;
    logic                w_grant_mem;
    logic                w_grant_any;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_data;
    logic                w_wb_unexpected;
    logic [ADDR_W:0]     w_busy_count;

    // Hazard check sees only registered busy bits; bit 0 is always 0 so x0
    // can never stall.
    always_comb begin
        w_stall = ~rst & bus.issue_valid &
                  ((bus.issue_use_rs1  & r_busy[bus.issue_rs1_addr]) |
                   (bus.issue_use_rs2  & r_busy[bus.issue_rs2_addr]) |
                   (bus.issue_rd_write & r_busy[bus.issue_rd_addr]));
        w_fire  = bus.issue_valid & ~w_stall;
    end

    // Round-robin: on conflict the source not granted last time wins.
    always_comb begin
        w_grant_alu = bus.alu_wb_valid & (~bus.mem_wb_valid | (r_last_grant == SRC_MEM));
        w_grant_mem = bus.mem_wb_valid & (~bus.alu_wb_valid | (r_last_grant == SRC_ALU));
        w_grant_any = w_grant_alu | w_grant_mem;
        w_win_addr  = w_grant_alu ? bus.alu_wb_addr : bus.mem_wb_addr;
        w_win_data  = w_grant_alu ? bus.alu_wb_data : bus.mem_wb_data;
        w_wb_unexpected = w_grant_any & (w_win_addr != '0) & ~r_busy[w_win_addr];
    end

    // Clear is applied before set so a same-register collision leaves it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wr_vld_p1)
            w_busy_nxt[r_wr_addr_p1] = 1'b0;
        if (w_fire && bus.issue_rd_write && (bus.issue_rd_addr != '0))
            w_busy_nxt[bus.issue_rd_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_busy_count = '0;
        for (int i = 0; i < NUM_REGS; i++)
            w_busy_count = w_busy_count + (ADDR_W+1)'(r_busy[i]);
    end

    // ---- p0 -> p1: grant cycle registers the winner onto the write port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy          <= '0;
            r_last_grant    <= SRC_MEM;
            r_wr_vld_p1     <= 1'b0;
            r_wr_addr_p1    <= '0;
            r_wr_data_p1    <= '0;
            r_wb_unexpected <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_grant_any) begin
                r_last_grant <= w_grant_alu ? SRC_ALU : SRC_MEM;
                r_wr_vld_p1  <= (w_win_addr != '0);
                r_wr_addr_p1 <= w_win_addr;
                r_wr_data_p1 <= w_win_data;
            end else begin
                r_wr_vld_p1  <= 1'b0;
            end
            if (w_wb_unexpected)
                r_wb_unexpected <= 1'b1;
        end
    end

    assign bus.issue_stall     = w_stall;
    assign bus.issue_fire      = w_fire;
    assign bus.alu_wb_ready    = w_grant_alu;
    assign bus.mem_wb_ready    = w_grant_mem;
    assign bus.rf_write_enable = r_wr_vld_p1;
    assign bus.rf_write_addr   = r_wr_addr_p1;
    assign bus.rf_write_data   = r_wr_data_p1;
    assign bus.busy_count      = w_busy_count;
    assign bus.wb_unexpected   = r_wb_unexpected;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Directed bench for regfile_scoreboard. Inputs change 1ns after the rising
//   edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.issue_valid    = 1'b0;
        bus.issue_use_rs1  = 1'b0;
        bus.issue_use_rs2  = 1'b0;
        bus.issue_rs1_addr = '0;
        bus.issue_rs2_addr = '0;
        bus.issue_rd_write = 1'b0;
        bus.issue_rd_addr  = '0;
        bus.alu_wb_valid   = 1'b0;
        bus.alu_wb_addr    = '0;
        bus.alu_wb_data    = '0;
        bus.mem_wb_valid   = 1'b0;
        bus.mem_wb_addr    = '0;
        bus.mem_wb_data    = '0;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        idle();
        bus.issue_valid    = 1'b1;
        bus.issue_rd_write = 1'b1;
        bus.issue_rd_addr  = rd;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        cyc(); cyc();
        smp();
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b exp 0", bus.rf_write_enable); end
        checks++; if (bus.rf_write_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d exp 0", bus.rf_write_addr); end
        checks++; if (bus.rf_write_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", bus.rf_write_data); end
        checks++; if (bus.busy_count !== 6'd0) begin errors++; $display("FAIL reset_busy_count: got %0d exp 0", bus.busy_count); end
        checks++; if (bus.wb_unexpected !== 1'b0) begin errors++; $display("FAIL reset_unexp: got %0b exp 0", bus.wb_unexpected); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_raw();
        issue_rd(5'd5);
        smp();
        checks++; if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL raw_issue_fire: got %0b exp 1", bus.issue_fire); end
        cyc();
        idle();
        bus.issue_valid = 1'b1; bus.issue_use_rs1 = 1'b1; bus.issue_rs1_addr = 5'd5;
        smp();
        checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %0b exp 1", bus.issue_stall); end
        checks++; if (bus.busy_count !== 6'd1) begin errors++; $display("FAIL raw_busy_count: got %0d exp 1", bus.busy_count); end
        cyc();  // cycle N: ALU writeback granted
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd5; bus.alu_wb_data = 32'hDEADBEEF;
        smp();
        checks++; if (bus.alu_wb_ready !== 1'b1) begin errors++; $display("FAIL raw_alu_ready: got %0b exp 1", bus.alu_wb_ready); end
        checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_N: got %0b exp 1", bus.issue_stall); end
        cyc();  // cycle N+1
        bus.alu_wb_valid = 1'b0;
        smp();
        checks++; if (bus.rf_write_enable !== 1'b1) begin errors++; $display("FAIL raw_we: got %0b exp 1", bus.rf_write_enable); end
        checks++; if (bus.rf_write_addr !== 5'd5) begin errors++; $display("FAIL raw_addr: got %0d exp 5", bus.rf_write_addr); end
        checks++; if (bus.rf_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_data: got %h exp deadbeef", bus.rf_write_data); end
        checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_N1: got %0b exp 1", bus.issue_stall); end
        cyc();  // cycle N+2
        smp();
        checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL raw_stall_N2: got %0b exp 0", bus.issue_stall); end
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL raw_we_N2: got %0b exp 0", bus.rf_write_enable); end
        checks++; if (bus.busy_count !== 6'd0) begin errors++; $display("FAIL raw_busy_N2: got %0d exp 0", bus.busy_count); end
        checks++; if (bus.wb_unexpected !== 1'b0) begin errors++; $display("FAIL raw_unexp: got %0b exp 0", bus.wb_unexpected); end
        cyc();
        idle();
    endtask

    task automatic test_both_sources();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        issue_rd(5'd3);
        cyc();
        issue_rd(5'd4);
        cyc();
        idle();
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd3; bus.alu_wb_data = 32'h11;
        bus.mem_wb_valid = 1'b1; bus.mem_wb_addr = 5'd4; bus.mem_wb_data = 32'h22;
        smp();
        checks++; if (bus.alu_wb_ready !== 1'b1 || bus.mem_wb_ready !== 1'b0) begin errors++; $display("FAIL both_first_grant: got alu=%0b mem=%0b exp alu=1 mem=0", bus.alu_wb_ready, bus.mem_wb_ready); end
        cyc();
        bus.alu_wb_valid = 1'b0;
        smp();
        checks++; if (bus.mem_wb_ready !== 1'b1) begin errors++; $display("FAIL both_second_grant: got %0b exp 1", bus.mem_wb_ready); end
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_write_addr !== 5'd3 || bus.rf_write_data !== 32'h11) begin errors++; $display("FAIL both_wr_x3: got we=%0b addr=%0d data=%h exp 1/3/11", bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data); end
        cyc();
        bus.mem_wb_valid = 1'b0;
        smp();
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_write_addr !== 5'd4 || bus.rf_write_data !== 32'h22) begin errors++; $display("FAIL both_wr_x4: got we=%0b addr=%0d data=%h exp 1/4/22", bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data); end
        cyc();
    endtask

    task automatic test_alternate();
        logic [4:0] alu_a [4] = '{5'd10, 5'd12, 5'd12, 5'd14};
        logic [4:0] mem_a [4] = '{5'd11, 5'd11, 5'd13, 5'd13};
        logic       exp_alu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int r = 10; r < 14; r++) begin
            issue_rd(5'(r));
            cyc();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = alu_a[i]; bus.alu_wb_data = 32'(alu_a[i]);
            bus.mem_wb_valid = 1'b1; bus.mem_wb_addr = mem_a[i]; bus.mem_wb_data = 32'(mem_a[i]);
            smp();
            checks++; if (bus.alu_wb_ready !== exp_alu[i] || bus.mem_wb_ready !== ~exp_alu[i]) begin errors++; $display("FAIL alt_grant%0d: got alu=%0b mem=%0b exp alu=%0b", i, bus.alu_wb_ready, bus.mem_wb_ready, exp_alu[i]); end
            if (i > 0) begin
                checks++; if (bus.rf_write_addr !== 5'(9 + i)) begin errors++; $display("FAIL alt_wr%0d: got %0d exp %0d", i, bus.rf_write_addr, 9 + i); end
            end
            cyc();
        end
        idle();
        smp();
        checks++; if (bus.rf_write_addr !== 5'd13 || bus.rf_write_data !== 32'd13) begin errors++; $display("FAIL alt_wr_last: got addr=%0d data=%0d exp 13/13", bus.rf_write_addr, bus.rf_write_data); end
        checks++; if (bus.wb_unexpected !== 1'b0) begin errors++; $display("FAIL alt_unexp: got %0b exp 0", bus.wb_unexpected); end
        cyc(); cyc();
        smp();
        checks++; if (bus.busy_count !== 6'd0) begin errors++; $display("FAIL alt_busy_count: got %0d exp 0", bus.busy_count); end
        cyc();
    endtask

    task automatic test_x0();
        issue_rd(5'd0);
        smp();
        checks++; if (bus.issue_stall !== 1'b0 || bus.issue_fire !== 1'b1) begin errors++; $display("FAIL x0_issue: got stall=%0b fire=%0b exp 0/1", bus.issue_stall, bus.issue_fire); end
        cyc();
        idle();
        bus.issue_valid = 1'b1; bus.issue_use_rs1 = 1'b1; bus.issue_rs1_addr = 5'd0;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd0; bus.alu_wb_data = 32'h55;
        smp();
        checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %0b exp 0", bus.issue_stall); end
        checks++; if (bus.busy_count !== 6'd0) begin errors++; $display("FAIL x0_busy_count: got %0d exp 0", bus.busy_count); end
        checks++; if (bus.alu_wb_ready !== 1'b1) begin errors++; $display("FAIL x0_alu_ready: got %0b exp 1", bus.alu_wb_ready); end
        cyc();
        idle();
        smp();
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL x0_we: got %0b exp 0", bus.rf_write_enable); end
        checks++; if (bus.wb_unexpected !== 1'b0) begin errors++; $display("FAIL x0_unexp: got %0b exp 0", bus.wb_unexpected); end
        cyc();
    endtask

    task automatic test_waw_unexpected();
        issue_rd(5'd7);
        cyc();
        issue_rd(5'd7);
        smp();
        checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL waw_stall0: got %0b exp 1", bus.issue_stall); end
        cyc();  // cycle N: memory writes x7
        bus.mem_wb_valid = 1'b1; bus.mem_wb_addr = 5'd7; bus.mem_wb_data = 32'h77;
        smp();
        checks++; if (bus.issue_stall !== 1'b1 || bus.mem_wb_ready !== 1'b1) begin errors++; $display("FAIL waw_stallN: got stall=%0b ready=%0b exp 1/1", bus.issue_stall, bus.mem_wb_ready); end
        cyc();
        bus.mem_wb_valid = 1'b0;
        smp();
        checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL waw_stallN1: got %0b exp 1", bus.issue_stall); end
        cyc();
        smp();
        checks++; if (bus.issue_stall !== 1'b0 || bus.issue_fire !== 1'b1) begin errors++; $display("FAIL waw_release: got stall=%0b fire=%0b exp 0/1", bus.issue_stall, bus.issue_fire); end
        cyc();
        idle();
        bus.mem_wb_valid = 1'b1; bus.mem_wb_addr = 5'd9; bus.mem_wb_data = 32'h99;
        smp();
        checks++; if (bus.busy_count !== 6'd1 || bus.wb_unexpected !== 1'b0) begin errors++; $display("FAIL waw_pre_unexp: got count=%0d unexp=%0b exp 1/0", bus.busy_count, bus.wb_unexpected); end
        cyc();
        bus.mem_wb_valid = 1'b0;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd7; bus.alu_wb_data = 32'h7;
        smp();
        checks++; if (bus.wb_unexpected !== 1'b1) begin errors++; $display("FAIL waw_unexp_set: got %0b exp 1", bus.wb_unexpected); end
        cyc();
        idle();
        cyc(); cyc();
        smp();
        checks++; if (bus.wb_unexpected !== 1'b1 || bus.busy_count !== 6'd0) begin errors++; $display("FAIL waw_unexp_sticky: got unexp=%0b count=%0d exp 1/0", bus.wb_unexpected, bus.busy_count); end
        cyc();
    endtask

    task automatic test_reset_midop();
        for (int r = 1; r <= 3; r++) begin
            issue_rd(5'(r));
            cyc();
        end
        idle();
        smp();
        checks++; if (bus.busy_count !== 6'd3) begin errors++; $display("FAIL mid_busy3: got %0d exp 3", bus.busy_count); end
        cyc();
        rst = 1'b1;
        bus.issue_valid = 1'b1; bus.issue_use_rs1 = 1'b1; bus.issue_rs1_addr = 5'd1;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd2; bus.alu_wb_data = 32'hAA;
        smp();
        checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall: got %0b exp 0", bus.issue_stall); end
        checks++; if (bus.alu_wb_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %0b exp 1", bus.alu_wb_ready); end
        cyc();
        rst = 1'b0;
        idle();
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd20; bus.alu_wb_data = 32'h1;
        bus.mem_wb_valid = 1'b1; bus.mem_wb_addr = 5'd21; bus.mem_wb_data = 32'h2;
        smp();
        checks++; if (bus.busy_count !== 6'd0) begin errors++; $display("FAIL mid_busy0: got %0d exp 0", bus.busy_count); end
        checks++; if (bus.rf_write_enable !== 1'b0 || bus.rf_write_addr !== 5'd0) begin errors++; $display("FAIL mid_we: got we=%0b addr=%0d exp 0/0", bus.rf_write_enable, bus.rf_write_addr); end
        checks++; if (bus.wb_unexpected !== 1'b0) begin errors++; $display("FAIL mid_unexp: got %0b exp 0", bus.wb_unexpected); end
        checks++; if (bus.alu_wb_ready !== 1'b1 || bus.mem_wb_ready !== 1'b0) begin errors++; $display("FAIL mid_conflict: got alu=%0b mem=%0b exp 1/0", bus.alu_wb_ready, bus.mem_wb_ready); end
        cyc();
        idle();
        cyc();
    endtask

    initial begin
        idle();
        test_reset();
        test_raw();
        test_both_sources();
        test_alternate();
        test_x0();
        test_waw_unexpected();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
